// File: rtl/cache_writeback_buffer_pkg.sv
// Shared LC-3b memory-side types and the write-back buffer FSM encoding.
package cache_writeback_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_DONE = 2'd2,
        ST_WR      = 2'd3
    } wb_state_e;

    // A line address is the byte address with the 16-byte offset removed.
    function automatic lc3b_line_addr to_line_addr(input lc3b_word addr);
        return lc3b_line_addr'(addr >> 4);
    endfunction

endpackage

// File: rtl/cache_writeback_buffer_wb_entry_file.sv
// Circular store of evicted lines with age-ordered lookup (newest match wins).
module cache_writeback_buffer_wb_entry_file
    import cache_writeback_buffer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  lc3b_line_addr     push_addr,
    input  lc3b_line          push_data,
    input  logic              pop,
    input  lc3b_line_addr     lookup_addr,
    output logic              hit,
    output lc3b_line          hit_data,
    output lc3b_line_addr     head_addr,
    output lc3b_line          head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DEPTH-1:0] valid;
    lc3b_line_addr    addr_mem [DEPTH];
    lc3b_line         data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] idx;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full buffer may still accept when the head is freed on the same edge.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop_ok) begin
                valid[head] <= 1'b0;
                head        <= next_ptr(head);
            end
            // Placed after the pop so a full-buffer push into the freed slot stays valid.
            if (push_ok) begin
                valid[tail] <= 1'b1;
                tail        <= next_ptr(tail);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        // Walk oldest to newest so the last match seen is the newest one.
        for (int i = 0; i < DEPTH; i++) begin
            idx = PTR_W'((int'(head) + i) % DEPTH);
            if (valid[idx] && (addr_mem[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

endmodule

// File: rtl/cache_writeback_buffer.sv
// Victim write buffer between the L1 pmem port and physical memory: 1-cycle
// eviction accept, background drain, and read forwarding from buffered lines.
module cache_writeback_buffer
    import cache_writeback_buffer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [15:0]       pmem_address,
    input  logic [127:0]      pmem_wdata,
    output logic              pmem_resp,
    output logic [127:0]      pmem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       mem_address,
    output logic [127:0]      mem_wdata,
    input  logic              mem_resp,
    input  logic [127:0]      mem_rdata,
    output logic [CNT_W-1:0]  wb_count,
    output logic              wb_full,
    output logic              wb_empty,
    output wb_state_e         fsm_state
);

    wb_state_e     state;
    wb_state_e     state_next;
    lc3b_line_addr req_line;
    lc3b_line_addr rd_line_q;
    lc3b_line_addr head_addr;
    lc3b_line      head_data;
    lc3b_line      hit_data;
    logic          hit;
    logic          req_ok;
    logic          wr_req;
    logic          rd_req;
    logic          rd_hit;
    logic          rd_miss_start;
    logic          rd_done;
    logic          pop;
    logic          push;

    assign req_line = to_line_addr(pmem_address);
    // Requests are held until pmem_resp, so they are only looked at while it is low.
    assign req_ok   = !pmem_resp && !(pmem_read && pmem_write);
    assign wr_req   = req_ok && pmem_write;
    assign rd_req   = req_ok && pmem_read && (state != ST_RD) && (state != ST_RD_DONE);

    assign pop           = (state == ST_WR) && mem_resp;
    assign push          = wr_req && (!wb_full || pop);
    assign rd_hit        = rd_req && hit;
    assign rd_miss_start = rd_req && !hit && (state == ST_IDLE);
    assign rd_done       = (state == ST_RD) && mem_resp;

    cache_writeback_buffer_wb_entry_file #(.DEPTH(DEPTH)) entries (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (req_line),
        .push_data   (pmem_wdata),
        .pop         (pop),
        .lookup_addr (req_line),
        .hit         (hit),
        .hit_data    (hit_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (wb_count),
        .full        (wb_full),
        .empty       (wb_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            rd_line_q  <= '0;
        end else begin
            state     <= state_next;
            pmem_resp <= push || rd_hit || rd_done;
            if (rd_hit) begin
                pmem_rdata <= hit_data;
            end else if (rd_done) begin
                pmem_rdata <= mem_rdata;
            end
            if (rd_miss_start) begin
                rd_line_q <= req_line;
            end
        end
    end

    // A read miss beats a drain only from IDLE; a started drain always finishes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rd_miss_start) begin
                    state_next = ST_RD;
                end else if (!wb_empty) begin
                    state_next = ST_WR;
                end
            end
            ST_RD: begin
                if (mem_resp) begin
                    state_next = ST_RD_DONE;
                end
            end
            ST_RD_DONE: state_next = ST_IDLE;
            ST_WR: begin
                if (mem_resp) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory-side outputs decode only flops, so there is no cache-to-memory comb path.
    assign mem_read    = (state == ST_RD);
    assign mem_write   = (state == ST_WR);
    assign mem_address = {((state == ST_WR) ? head_addr : rd_line_q), 4'h0};
    assign mem_wdata   = head_data;
    assign fsm_state   = state;

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Bench for cache_writeback_buffer: cache driver tasks, a responding memory,
// and a line-level reference model of buffered evictions.
module tb_cache_writeback_buffer;
    import cache_writeback_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [127:0] LA = {4{32'h1111_0001}};
    localparam logic [127:0] LB = {4{32'h2222_0002}};
    localparam logic [127:0] LC = {4{32'h3333_0003}};
    localparam logic [127:0] LD = {4{32'h4444_0004}};

    logic             clk;
    logic             rst_n;
    logic             pmem_read;
    logic             pmem_write;
    logic [15:0]      pmem_address;
    logic [127:0]     pmem_wdata;
    logic             pmem_resp;
    logic [127:0]     pmem_rdata;
    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_address;
    logic [127:0]     mem_wdata;
    logic             mem_resp;
    logic [127:0]     mem_rdata;
    logic [CNT_W-1:0] wb_count;
    logic             wb_full;
    logic             wb_empty;
    wb_state_e        fsm_state;

    int n_checks;
    int n_fail;
    int cyc;
    int last_resp_cyc;
    int last_wr_resp_cyc;
    int mem_lat;
    bit mem_stall;

    logic [143:0] exp_q[$];                  // buffered lines, oldest first: {addr, data}
    logic [127:0] mem_model [logic [11:0]];
    logic [16:0]  op_log[$];                 // completed memory ops: {is_write, addr}

    cache_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .wb_count     (wb_count),
        .wb_full      (wb_full),
        .wb_empty     (wb_empty),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [127:0] mem_value(input logic [11:0] line);
        if (mem_model.exists(line)) return mem_model[line];
        return '0;
    endfunction

    function automatic logic [127:0] model_read(input logic [15:0] a);
        logic [143:0] e;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            e = exp_q[i];
            if (e[143:132] == a[15:4]) return e[127:0];
        end
        return mem_value(a[15:4]);
    endfunction

    // ---------------- memory responder + scoreboard ----------------
    initial begin : responder
        int wait_cnt;
        logic [143:0] e;
        mem_resp = 1'b0;
        mem_rdata = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            assert (!(pmem_read && pmem_write)) else $error("illegal cache request: read and write together");
            if (rst_n && (mem_read || mem_write)) begin
                n_checks++;
                if (mem_read && mem_write) begin
                    n_fail++;
                    $display("FAIL strobe_overlap: mem_read=%b mem_write=%b, required never both", mem_read, mem_write);
                end
            end
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (rst_n && !mem_stall && (mem_read || mem_write)) begin
                if (wait_cnt >= mem_lat) begin
                    wait_cnt = 0;
                    mem_resp = 1'b1;
                    if (mem_read) begin
                        op_log.push_back({1'b0, mem_address});
                        mem_rdata = mem_value(mem_address[15:4]);
                    end else begin
                        op_log.push_back({1'b1, mem_address});
                        last_wr_resp_cyc = cyc;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL drain_order: unexpected write addr=%h, no line buffered", mem_address);
                        end else begin
                            e = exp_q.pop_front();
                            if ({mem_address, mem_wdata} !== e) begin
                                n_fail++;
                                $display("FAIL drain_data: got addr=%h data=%h, expected addr=%h data=%h",
                                         mem_address, mem_wdata, e[143:128], e[127:0]);
                            end
                        end
                        mem_model[mem_address[15:4]] = mem_wdata;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- cache-side driver tasks ----------------
    task automatic cache_write(input logic [15:0] a, input logic [127:0] d, output int lat);
        bit done;
        for (int k = 0; k < 4 && pmem_resp; k++) @(negedge clk);
        done = 1'b0;
        lat = 0;
        pmem_address = a;
        pmem_wdata = d;
        pmem_write = 1'b1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (pmem_resp) done = 1'b1;
        end
        pmem_write = 1'b0;
        last_resp_cyc = cyc;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_timeout: addr=%h no pmem_resp within %0d cycles", a, lat);
        end else begin
            exp_q.push_back({a & 16'hfff0, d});
        end
    endtask

    task automatic cache_read(input logic [15:0] a, output logic [127:0] d, output logic [127:0] e, output int lat);
        bit done;
        for (int k = 0; k < 4 && pmem_resp; k++) @(negedge clk);
        done = 1'b0;
        lat = 0;
        d = '0;
        e = model_read(a);
        pmem_address = a;
        pmem_read = 1'b1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (pmem_resp) begin
                done = 1'b1;
                d = pmem_rdata;
            end
        end
        pmem_read = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL read_timeout: addr=%h no pmem_resp within %0d cycles", a, lat);
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (!(wb_empty && fsm_state == ST_IDLE && !mem_resp) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout: wb_count=%0d after %0d cycles, required 0", wb_count, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wb_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d required 0", wb_count); end
        n_checks++;
        if (wb_empty !== 1'b1 || wb_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b required 1/0", wb_empty, wb_full);
        end
        n_checks++;
        if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b required 0", pmem_resp); end
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: read=%b write=%b required 0/0", mem_read, mem_write);
        end
    endtask

    task automatic test_single_write();
        int lat;
        int n0;
        mem_stall = 1'b0;
        mem_lat = 2;
        n0 = op_log.size();
        cache_write(16'h1230, LA, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d required 1", lat); end
        n_checks++;
        if (wb_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_count: got %0d required 1", wb_count); end
        wait_drained();
        n_checks++;
        if (op_log.size() != n0 + 1 || op_log[n0] !== {1'b1, 16'h1230}) begin
            n_fail++; $display("FAIL single_drain: ops=%0d required 1 write to 1230", op_log.size() - n0);
        end
        n_checks++;
        if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b required 1", wb_empty); end
    endtask

    task automatic test_forward();
        int lat;
        int n0;
        logic [127:0] d;
        logic [127:0] e;
        n0 = op_log.size();
        mem_stall = 1'b1;
        cache_write(16'h2000, LB, lat);
        cache_read(16'h2008, d, e, lat);
        n_checks++;
        if (d !== LB) begin n_fail++; $display("FAIL forward_data: got %h required %h", d, LB); end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL forward_latency: got %0d required 1", lat); end
        mem_stall = 1'b0;
        wait_drained();
        n_checks++;
        if (op_log.size() != n0 + 1 || op_log[n0] !== {1'b1, 16'h2000}) begin
            n_fail++; $display("FAIL forward_no_read: ops=%0d required only the write of 2000", op_log.size() - n0);
        end
    endtask

    task automatic test_full_stall();
        int lat;
        int lat3;
        int n0;
        logic [16:0] exp_ops [3];
        exp_ops[0] = {1'b1, 16'h0100};
        exp_ops[1] = {1'b1, 16'h0200};
        exp_ops[2] = {1'b1, 16'h0300};
        n0 = op_log.size();
        mem_stall = 1'b1;
        mem_lat = 1;
        cache_write(16'h0100, LA, lat);
        cache_write(16'h0200, LB, lat);
        n_checks++;
        if (wb_full !== 1'b1 || wb_count !== CNT_W'(DEPTH)) begin
            n_fail++; $display("FAIL full_flags: full=%b count=%0d required 1/%0d", wb_full, wb_count, DEPTH);
        end
        fork
            cache_write(16'h0300, LC, lat3);
            begin
                repeat (6) @(negedge clk);
                mem_stall = 1'b0;
            end
        join
        n_checks++;
        if (last_resp_cyc != last_wr_resp_cyc + 1) begin
            n_fail++; $display("FAIL full_accept: resp cycle %0d required %0d", last_resp_cyc, last_wr_resp_cyc + 1);
        end
        n_checks++;
        if (lat3 <= 6) begin n_fail++; $display("FAIL full_stall: latency %0d required > 6", lat3); end
        wait_drained();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (op_log.size() != n0 + 3 || op_log[n0 + i] !== exp_ops[i]) begin
                n_fail++; $display("FAIL full_order[%0d]: got %h required %h", i, op_log[n0 + i], exp_ops[i]);
            end
        end
    endtask

    task automatic test_read_priority();
        int lat;
        int n0;
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] r;
        logic [16:0] exp_ops [3];
        exp_ops[0] = {1'b1, 16'h3000};
        exp_ops[1] = {1'b0, 16'h5000};
        exp_ops[2] = {1'b1, 16'h4000};
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_model[12'h500] = r;
        n0 = op_log.size();
        mem_stall = 1'b1;
        mem_lat = 1;
        cache_write(16'h3000, LC, lat);
        cache_write(16'h4000, LD, lat);
        fork
            cache_read(16'h5000, d, e, lat);
            begin
                repeat (4) @(negedge clk);
                n_checks++;
                if (mem_read !== 1'b0) begin n_fail++; $display("FAIL read_waits_drain: mem_read=%b required 0", mem_read); end
                mem_stall = 1'b0;
            end
        join
        n_checks++;
        if (d !== r || d !== e) begin n_fail++; $display("FAIL miss_data: got %h required %h", d, r); end
        wait_drained();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (op_log.size() != n0 + 3 || op_log[n0 + i] !== exp_ops[i]) begin
                n_fail++; $display("FAIL priority_order[%0d]: got %h required %h", i, op_log[n0 + i], exp_ops[i]);
            end
        end
    endtask

    task automatic test_rewrite();
        int lat;
        int n0;
        logic [127:0] d;
        logic [127:0] e;
        n0 = op_log.size();
        mem_stall = 1'b1;
        cache_write(16'h7000, LA, lat);
        cache_read(16'h7000, d, e, lat);
        n_checks++;
        if (d !== LA) begin n_fail++; $display("FAIL rewrite_first: got %h required %h", d, LA); end
        cache_write(16'h7000, LB, lat);
        cache_read(16'h7004, d, e, lat);
        n_checks++;
        if (d !== LB) begin n_fail++; $display("FAIL rewrite_newest: got %h required %h", d, LB); end
        mem_stall = 1'b0;
        wait_drained();
        n_checks++;
        if (op_log.size() != n0 + 2 || op_log[n0] !== {1'b1, 16'h7000} || op_log[n0 + 1] !== {1'b1, 16'h7000}) begin
            n_fail++; $display("FAIL rewrite_drains: ops=%0d required 2 writes to 7000", op_log.size() - n0);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a;
        logic [127:0] d;
        logic [127:0] e;
        logic [15:0] lines [4];
        lines[0] = 16'h8000;
        lines[1] = 16'h8010;
        lines[2] = 16'h8020;
        lines[3] = 16'h9000;
        mem_stall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            mem_lat = $urandom_range(0, 3);
            a = lines[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                cache_write(a, {$urandom(), $urandom(), $urandom(), $urandom()}, lat);
            end else begin
                cache_read(a, d, e, lat);
                n_checks++;
                if (d !== e) begin n_fail++; $display("FAIL random_read[%0d]: addr=%h got %h required %h", i, a, d, e); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drained();
    endtask

    task automatic test_reset_midwrite();
        int lat;
        int n0;
        mem_stall = 1'b1;
        cache_write(16'h0a00, LC, lat);
        cache_write(16'h0b00, LD, lat);
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1 || wb_count !== CNT_W'(2)) begin
            n_fail++; $display("FAIL pre_reset: mem_write=%b count=%0d required 1/2", mem_write, wb_count);
        end
        n0 = op_log.size();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b0 || wb_count !== CNT_W'(0)) begin
            n_fail++; $display("FAIL reset_abort: mem_write=%b count=%0d required 0/0", mem_write, wb_count);
        end
        exp_q.delete();
        mem_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (op_log.size() != n0 || wb_empty !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_quiet: ops=%0d empty=%b required 0 ops, empty", op_log.size() - n0, wb_empty);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        last_resp_cyc = 0;
        last_wr_resp_cyc = 0;
        mem_lat = 1;
        mem_stall = 1'b0;
        rst_n = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        test_reset();
        test_single_write();
        test_forward();
        test_full_stall();
        test_read_priority();
        test_rewrite();
        test_random();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
